// File: rtl/vga_plot_arbiter_pkg.sv
// Shared screen geometry, colour constants and arbiter state encoding for the VGA plot path.
// Imported by the arbiter top and its round-robin picker.
package vga_plot_arbiter_pkg;

  localparam int DEF_X_W     = 9;
  localparam int DEF_Y_W     = 8;
  localparam int DEF_COLOR_W = 3;
  localparam int SCREEN_W    = 320;
  localparam int SCREEN_H    = 240;
  localparam int GRANT_W     = 3;

  localparam logic [2:0] COLOR_BLACK     = 3'b000;
  localparam logic [2:0] DEF_CLEAR_COLOR = COLOR_BLACK;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    GRANT = 2'd2
  } state_t;

  // Round-robin search starts one past the previous owner, wrapping at n.
  function automatic logic [GRANT_W-1:0] rr_next(input logic [GRANT_W-1:0] cur, input int n);
    logic [GRANT_W-1:0] nxt;
    if (int'(cur) >= n - 1) nxt = '0;
    else                    nxt = cur + 1'b1;
    return nxt;
  endfunction

endpackage

// File: rtl/vga_plot_arbiter_rr_select.sv
// Combinational round-robin pick: first set bit of valid at or above ptr, wrapping modulo N.
// Zero latency; found is low when no bit of valid is set.
module rr_select #(
  parameter int N     = 3,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [N-1:0]     rot;
  logic [IDX_W-1:0] off;
  logic [IDX_W:0]   sum;

  always_comb begin
    // Rotate so that bit 0 is the requester at ptr; the lowest set bit is then the winner.
    rot   = N'({valid, valid} >> ptr);
    found = |rot;
    off   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = IDX_W'(k);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IDX_W + 1)'(N)) sum = sum - (IDX_W + 1)'(N);
    idx = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Packet-granular round-robin arbiter plus full-screen clear sweep driving one vga_adapter write port.
// Plot/X/Y/color are registered one cycle after beat acceptance; only the owner sees ready, others stall.
module vga_plot_arbiter
  import vga_plot_arbiter_pkg::*;
#(
  parameter int                 NUM_REQ     = 3,
  parameter int                 X_W         = DEF_X_W,
  parameter int                 Y_W         = DEF_Y_W,
  parameter int                 COLOR_W     = DEF_COLOR_W,
  parameter int                 X_MAX       = SCREEN_W - 1,
  parameter int                 Y_MAX       = SCREEN_H - 1,
  parameter logic [COLOR_W-1:0] CLEAR_COLOR = COLOR_W'(DEF_CLEAR_COLOR)
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       clear_start,
  output logic                       clear_busy,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_last,
  input  logic [NUM_REQ*X_W-1:0]     req_x,
  input  logic [NUM_REQ*Y_W-1:0]     req_y,
  input  logic [NUM_REQ*COLOR_W-1:0] req_color,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [GRANT_W-1:0]         grant_id,
  output logic                       plot,
  output logic [X_W-1:0]             X,
  output logic [Y_W-1:0]             Y,
  output logic [COLOR_W-1:0]         color
);

  state_t               state;
  logic                 clear_pending;
  logic [X_W-1:0]       sweep_x;
  logic [Y_W-1:0]       sweep_y;

  logic [GRANT_W-1:0]   rr_start;
  logic [GRANT_W-1:0]   pick_idx;
  logic                 pick_found;

  logic                 cur_valid;
  logic                 cur_last;
  logic [X_W-1:0]       cur_x;
  logic [Y_W-1:0]       cur_y;
  logic [COLOR_W-1:0]   cur_color;
  logic                 cur_in_range;

  assign rr_start = rr_next(grant_id, NUM_REQ);

  rr_select #(
    .N     (NUM_REQ),
    .IDX_W (GRANT_W)
  ) u_rr_select (
    .valid (req_valid),
    .ptr   (rr_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Beat fields of the current owner.
  always_comb begin
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    cur_x     = '0;
    cur_y     = '0;
    cur_color = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == GRANT_W'(i)) begin
        cur_valid = req_valid[i];
        cur_last  = req_last[i];
        cur_x     = req_x[i*X_W +: X_W];
        cur_y     = req_y[i*Y_W +: Y_W];
        cur_color = req_color[i*COLOR_W +: COLOR_W];
      end
    end
  end

  assign cur_in_range = (cur_x <= X_W'(X_MAX)) && (cur_y <= Y_W'(Y_MAX));

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state == GRANT) && (grant_id == GRANT_W'(i));
    end
  end

  assign clear_busy = clear_pending | (state == CLEAR);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      clear_pending <= 1'b0;
      grant_id      <= '0;
      sweep_x       <= '0;
      sweep_y       <= '0;
      plot          <= 1'b0;
      X             <= '0;
      Y             <= '0;
      color         <= '0;
    end else begin
      plot <= 1'b0;
      // A request arriving during a sweep restarts it instead of queueing a second sweep.
      if (clear_start && (state != CLEAR)) clear_pending <= 1'b1;

      case (state)
        IDLE: begin
          if (clear_pending) begin
            state         <= CLEAR;
            sweep_x       <= '0;
            sweep_y       <= '0;
            clear_pending <= 1'b0;
          end else if (pick_found) begin
            grant_id <= pick_idx;
            state    <= GRANT;
          end
        end

        GRANT: begin
          if (cur_valid) begin
            // Off-screen beats are consumed silently so the packet still terminates on its last beat.
            if (cur_in_range) begin
              plot  <= 1'b1;
              X     <= cur_x;
              Y     <= cur_y;
              color <= cur_color;
            end
            if (cur_last) state <= IDLE;
          end
        end

        CLEAR: begin
          plot  <= 1'b1;
          X     <= sweep_x;
          Y     <= sweep_y;
          color <= CLEAR_COLOR;
          if (clear_start) begin
            sweep_x <= '0;
            sweep_y <= '0;
          end else if (sweep_x == X_W'(X_MAX)) begin
            sweep_x <= '0;
            if (sweep_y == Y_W'(Y_MAX)) state <= IDLE;
            else                        sweep_y <= sweep_y + 1'b1;
          end else begin
            sweep_x <= sweep_x + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Scoreboard bench for vga_plot_arbiter: drivers push expected pixels at beat acceptance,
// a negedge monitor pops and compares on every plot strobe.
module tb_vga_plot_arbiter;

  localparam int N = 3;

  typedef struct {
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] c;
    bit         chk_busy;
    bit         busy;
  } exp_t;

  logic           clock       = 1'b0;
  logic           resetn      = 1'b1;
  logic           clear_start = 1'b0;
  logic           clear_busy;
  logic [N-1:0]   req_valid, req_last, req_ready;
  logic [N*9-1:0] req_x;
  logic [N*8-1:0] req_y;
  logic [N*3-1:0] req_color;
  logic [2:0]     grant_id;
  logic           plot;
  logic [8:0]     X;
  logic [7:0]     Y;
  logic [2:0]     color;

  logic       rv [N];
  logic       rl [N];
  logic [8:0] rx [N];
  logic [7:0] ry [N];
  logic [2:0] rc [N];

  exp_t exp_q[$];
  int   grant_log[$];
  int   tests = 0;
  int   fails = 0;
  exp_t mon_e;

  always_comb begin
    req_valid = '0;
    req_last  = '0;
    req_x     = '0;
    req_y     = '0;
    req_color = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = rv[i];
      req_last[i]        = rl[i];
      req_x[i*9 +: 9]    = rx[i];
      req_y[i*8 +: 8]    = ry[i];
      req_color[i*3 +: 3] = rc[i];
    end
  end

  vga_plot_arbiter #(.NUM_REQ(N)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_x       (req_x),
    .req_y       (req_y),
    .req_color   (req_color),
    .req_ready   (req_ready),
    .grant_id    (grant_id),
    .plot        (plot),
    .X           (X),
    .Y           (Y),
    .color       (color)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (resetn === 1'b1 && plot === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_plot: got plot at (%0d,%0d) color %0d, expected no plot at %0t", X, Y, color, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("plot_x", 32'(X), 32'(mon_e.x));
        check("plot_y", 32'(Y), 32'(mon_e.y));
        check("plot_color", 32'(color), 32'(mon_e.c));
        if (mon_e.chk_busy) check("busy_at_pixel", 32'(clear_busy), 32'(mon_e.busy));
      end
    end
  end

  task automatic send_beat(input int i, input int x, input int y, input int c, input bit last, output int waited);
    rv[i[1:0]] = 1'b1;
    rx[i[1:0]] = x[8:0];
    ry[i[1:0]] = y[7:0];
    rc[i[1:0]] = c[2:0];
    rl[i[1:0]] = last;
    waited = 0;
    while (1) begin
      @(negedge clock);
      if (req_ready[i[1:0]] === 1'b1) break;
      waited++;
      if (waited > 300) begin
        tests++;
        fails++;
        $display("FAIL ready_timeout: requester %0d got no ready, expected ready within 300 cycles", i);
        rv[i[1:0]] = 1'b0;
        rl[i[1:0]] = 1'b0;
        return;
      end
    end
    check("grant_id_at_accept", 32'(grant_id), 32'(i));
    if (x <= 319 && y <= 239) exp_q.push_back('{x[8:0], y[7:0], c[2:0], 1'b0, 1'b0});
    @(posedge clock);
    #1;
    rv[i[1:0]] = 1'b0;
    rl[i[1:0]] = 1'b0;
  endtask

  task automatic send_pkt(input int i, input int n, input int x0, input int y, input int c,
                          input int stall_after, output int max_wait);
    int w;
    max_wait = 0;
    for (int b = 0; b < n; b++) begin
      send_beat(i, x0 + b, y, c, (b == n - 1), w);
      if (b == 0) grant_log.push_back(i);
      else if (w > max_wait) max_wait = w;
      if (b == stall_after) begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clock);
          check("stall_ready", 32'(req_ready), 32'(1) << i);
          check("stall_grant", 32'(grant_id), 32'(i));
          if (k > 0) check("stall_plot", 32'(plot), 32'd0);
        end
        @(posedge clock);
        #1;
      end
    end
  endtask

  task automatic push_clear(input int count);
    for (int k = 0; k < count; k++) begin
      exp_q.push_back('{9'(k % 320), 8'(k / 320), 3'b000, 1'b1, (k != 76799)});
    end
  endtask

  task automatic wait_drain(input int budget, input string name, output int ready_hits);
    int n;
    n = 0;
    ready_hits = 0;
    while (exp_q.size() != 0) begin
      @(posedge clock);
      #2;
      if (req_ready !== '0) ready_hits++;
      n++;
      if (n > budget) begin
        tests++;
        fails++;
        $display("FAIL %s: %0d pixels still pending, expected 0 after %0d cycles", name, exp_q.size(), budget);
        exp_q.delete();
        return;
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_plot"},       32'(plot),       32'd0);
    check({tag, "_x"},          32'(X),          32'd0);
    check({tag, "_y"},          32'(Y),          32'd0);
    check({tag, "_color"},      32'(color),      32'd0);
    check({tag, "_clear_busy"}, 32'(clear_busy), 32'd0);
    check({tag, "_req_ready"},  32'(req_ready),  32'd0);
    check({tag, "_grant_id"},   32'(grant_id),   32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected completion before 2000000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, w1, w2, hits, n;
    for (int i = 0; i < N; i++) begin
      rv[i] = 1'b0; rl[i] = 1'b0; rx[i] = '0; ry[i] = '0; rc[i] = '0;
    end
    #1 resetn = 1'b0;
    #11;
    check_reset_vals("rst");
    @(posedge clock); #1 resetn = 1'b1;

    // Full-screen clear: 76800 black pixels in raster order.
    @(posedge clock); #1 clear_start = 1'b1;
    push_clear(76800);
    @(posedge clock); #1 clear_start = 1'b0;
    @(negedge clock);
    check("clear_busy_pending", 32'(clear_busy), 32'd1);
    check("clear_first_gap_plot", 32'(plot), 32'd0);
    wait_drain(80000, "full_clear", hits);
    check("full_clear_ready_low", 32'(hits), 32'd0);
    check("clear_busy_after", 32'(clear_busy), 32'd0);
    @(negedge clock);
    check("clear_no_extra_plot", 32'(plot), 32'd0);

    // Round-robin order 1,2,0 with whole packets.
    grant_log.delete();
    fork
      send_pkt(1, 4, 10, 20, 5, -1, w1);
      send_pkt(2, 2, 50, 60, 3, -1, w2);
      send_pkt(0, 2, 100, 110, 6, -1, w0);
    join
    wait_drain(10, "rr_drain", hits);
    check("req1_ready_held", 32'(w1), 32'd0);
    check("rr_count", 32'(grant_log.size()), 32'd3);
    if (grant_log.size() == 3) begin
      check("rr_order0", 32'(grant_log[0]), 32'd1);
      check("rr_order1", 32'(grant_log[1]), 32'd2);
      check("rr_order2", 32'(grant_log[2]), 32'd0);
    end

    // Stall mid-packet on requester 0 while requester 2 waits.
    grant_log.delete();
    fork
      send_pkt(0, 5, 200, 100, 1, 2, w0);
      begin
        repeat (3) @(posedge clock);
        #1;
        send_pkt(2, 2, 60, 70, 2, -1, w2);
      end
    join
    wait_drain(10, "stall_drain", hits);
    check("stall_count", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) check("stall_order", 32'(grant_log[1]), 32'd2);

    // Off-screen beats are accepted without a strobe.
    send_beat(1, 320, 5, 2, 1'b1, w1);
    @(negedge clock);
    check("oor_x_no_plot", 32'(plot), 32'd0);
    check("oor_x_hold", 32'(X), 32'd61);
    send_beat(1, 5, 240, 2, 1'b0, w1);
    send_beat(1, 7, 8, 4, 1'b1, w1);
    wait_drain(10, "oor_drain", hits);

    // clear_start mid-packet, then reset during the sweep.
    fork
      send_pkt(2, 4, 30, 40, 7, -1, w2);
      begin
        n = 0;
        while (req_ready[2] !== 1'b1 && n < 50) begin
          @(negedge clock);
          n++;
        end
        @(posedge clock); #1 clear_start = 1'b1;
        @(posedge clock); #1 clear_start = 1'b0;
        @(negedge clock);
        check("mid_pkt_busy", 32'(clear_busy), 32'd1);
        check("mid_pkt_ready", 32'(req_ready), 32'b100);
      end
    join
    rv[0] = 1'b1; rx[0] = 9'd5; ry[0] = 8'd5; rc[0] = 3'd1; rl[0] = 1'b1;
    push_clear(1000);
    @(negedge clock);
    check("pkt_end_ready", 32'(req_ready), 32'd0);
    check("pkt_end_busy", 32'(clear_busy), 32'd1);
    @(negedge clock);
    check("clear_entry_plot", 32'(plot), 32'd0);
    check("clear_entry_busy", 32'(clear_busy), 32'd1);
    wait_drain(1100, "clear_1000", hits);
    check("sweep_ready_low", 32'(hits), 32'd0);
    resetn = 1'b0;
    rv[0] = 1'b0;
    rl[0] = 1'b0;
    #1;
    check_reset_vals("rst_mid_clear");
    @(posedge clock);
    @(posedge clock); #1 resetn = 1'b1;
    @(posedge clock); #1 clear_start = 1'b1;
    push_clear(3);
    @(posedge clock); #1 clear_start = 1'b0;
    wait_drain(20, "clear_restart", hits);
    resetn = 1'b0;
    #1;
    check("final_rst_plot", 32'(plot), 32'd0);
    @(posedge clock); #1 resetn = 1'b1;
    repeat (2) @(posedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
